nios2_system_led_pwm: RTL

//  Downstream stage of the LED PIO: consumes the 10-bit LED pattern and drives the board LED pins.

---
 rtl/nios2_system_led_pwm_pkg.sv | 22 ++
 rtl/nios2_system_led_pwm_timebase.sv | 37 +++
 rtl/nios2_system_led_pwm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nios2_system_led_pwm_pkg.sv
// Shared definitions for the LED PWM stage: register map, CTRL bit positions,
// PWM counter width and register reset values.
package nios2_system_led_pwm_pkg;

  localparam int unsigned PWM_W = 8;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_DUTY  = 2'd1,
    REG_BLINK = 2'd2,
    REG_STAT  = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;

  localparam logic [1:0]       CTRL_RESET  = '0;
  localparam logic [PWM_W-1:0] DUTY_RESET  = '1;
  localparam logic [15:0]      BLINK_RESET = '0;
  localparam logic [PWM_W-1:0] PWM_MAX     = '1;

endpackage

// File: rtl/nios2_system_led_pwm_timebase.sv
// PWM timebase: prescaler producing a one-clock tick every PRESCALE clocks and
// an 8-bit PWM counter advanced by that tick. period_start marks the tick on
// which the counter wraps 255 -> 0.
module nios2_system_led_pwm_timebase
  import nios2_system_led_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 196
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             tick,
  output logic             period_start,
  output logic [PWM_W-1:0] pwm_cnt
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;

  assign tick         = (prescaler == PS_LAST);
  assign period_start = tick && (pwm_cnt == PWM_MAX);

  // Prescaler: count 0..PRESCALE-1, wrapping on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 1'b1;
  end

  // PWM counter: advance once per tick, natural 8-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

endmodule

// File: rtl/nios2_system_led_pwm.sv
// LED output stage behind the LED PIO: registers the pattern, applies global
// PWM dimming and optional blinking, configured through an Avalon-MM slave.
module nios2_system_led_pwm
  import nios2_system_led_pwm_pkg::*;
#(
  parameter int unsigned N_LEDS   = 10,
  parameter int unsigned PRESCALE = 196
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] led_out
);

  logic [1:0]        ctrl;
  logic [PWM_W-1:0]  duty;
  logic [15:0]       blink;
  logic [PWM_W-1:0]  duty_active;
  logic [15:0]       blink_cnt;
  logic              blink_phase;
  logic [N_LEDS-1:0] pattern_q;

  logic              tick;
  logic              period_start;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              wr;
  logic              blink_active;
  logic              blink_wr;
  logic              pwm_on;
  logic              phase_eff;
  logic              unused_bits;

  nios2_system_led_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .period_start (period_start),
    .pwm_cnt      (pwm_cnt)
  );

  assign wr           = chipselect && !write_n;
  assign blink_wr     = wr && (address == REG_BLINK);
  assign blink_active = ctrl[CTRL_BLINK_EN] && (blink != '0);
  assign pwm_on       = (duty_active == PWM_MAX) || (pwm_cnt < duty_active);
  // Gate with blink_active directly so disabling blink restores the pattern
  // on the first clock after CTRL changes, not one later via blink_phase.
  assign phase_eff    = blink_active ? blink_phase : 1'b1;
  assign unused_bits  = ^{writedata[31:16], tick};

  // Register file writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl  <= CTRL_RESET;
      duty  <= DUTY_RESET;
      blink <= BLINK_RESET;
    end else if (wr) begin
      case (address)
        REG_CTRL:  ctrl  <= writedata[1:0];
        REG_DUTY:  duty  <= writedata[PWM_W-1:0];
        REG_BLINK: blink <= writedata[15:0];
        default:   ;
      endcase
    end
  end

  // Duty shadow: only reload at a period boundary so no period is cut short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          duty_active <= DUTY_RESET;
    else if (period_start) duty_active <= duty;
  end

  // Blink counter and phase, counted in PWM periods.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!blink_active) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_wr) begin
      blink_cnt   <= '0;
    end else if (period_start) begin
      // >= so that shrinking BLINK below the current count still terminates.
      if (blink_cnt >= blink - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 16'd1;
      end
    end
  end

  // Pattern capture and gated LED output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      led_out   <= '0;
    end else begin
      pattern_q <= pattern_in;
      led_out   <= ctrl[CTRL_ENABLE] ? (pattern_q & {N_LEDS{pwm_on && phase_eff}}) : '0;
    end
  end

  // Read mux, combinational on address.
  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL:  readdata[1:0]       = ctrl;
      REG_DUTY:  readdata[PWM_W-1:0] = duty;
      REG_BLINK: readdata[15:0]      = blink;
      REG_STAT:  readdata[9:0]       = {(duty_active == duty), blink_phase, pwm_cnt};
      default:   readdata            = '0;
    endcase
  end

endmodule
